cmp_fu: RTL and testbench
=========================

Name: cmp_fu

Overview:
Compare/branch functional unit. It is the consumer end of the compare reservation-station issue interface. It accepts one issued branch/jump per cycle and evaluates it in a two-stage pipeline: an operand stage (S1) and a result stage (S2). The S2 result is held until the CDB arbiter grants it, and the branch resolution is published to the front end in the same cycle.

Parameters:
ROB_WIDTH, 3, width of ROB index carried with each instruction

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (0 = in reset)
flush  in  1  branch-recovery flush request
flush_tag  in  branch_tag_t  tag of mispredicted branch
issue  in  1  RS presents a ready instruction
operand1  in  32  rs1 value
operand2  in  32  rs2 value
br_tag_in  in  branch_tag_t  speculation tag of instruction
dest_ROB_in  in  ROB_WIDTH  destination ROB entry
cmp_type_in  in  1  0 = branch, 1 = jump
cmp_op_in  in  3  branch: funct3; jump: bit0 0 = JAL, 1 = JALR
imm_val_in  in  32  sign-extended immediate
pc_val_in  in  32  instruction PC
running  out  1  unit cannot accept this cycle
commit_taken  out  1  issued instruction accepted this cycle
cdb_req  out  1  S2 holds a result requesting the CDB
cdb_grant  in  1  arbiter grants CDB to this unit this cycle
cdb_out  out  CDB_output_t  {dest_ROB, rd_v, commit_valid}
br_resolve_valid  out  1  branch resolution valid (equals cdb_req && cdb_grant)
br_taken  out  1  resolved direction
br_target  out  32  next PC (target if taken, else pc+4)
br_tag_out  out  branch_tag_t  tag of resolving instruction

Behaviour:
- Reset (rst = 0, asynchronous): s1_valid = s2_valid = 0; all S1/S2 payload registers = 0. Outputs during reset: cdb_req = 0, cdb_out = 0, br_* = 0, running = 0, commit_taken = 0.
- Control equations:
  - s2_free = !s2_valid || cdb_grant
  - s1_free = !s1_valid || s2_free
  - running = !s1_free
  - commit_taken = issue && s1_free
- The combinational path cdb_grant -> running is allowed and required.
- Accept: when commit_taken is high, S1 captures the operands, tag, ROB index, type, op, imm and pc at the edge.
- S1 -> S2 transfer: when s1_valid && s2_free, the S2 result is computed from S1 and registered.
- Latency: accepted at edge N, cdb_req at N+2 at the earliest. Sustained throughput is 1 per cycle while cdb_grant stays high.
- Branch compare (cmp_type = 0), on operand1/operand2:
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010 and 011 give taken = 0.
  - br_target = taken ? pc + imm : pc + 4.
  - rd_v = 0.
- Jump (cmp_type = 1):
  - taken = 1; rd_v = pc + 4.
  - JAL target = pc + imm.
  - JALR target = (operand1 + imm) & ~32'h1.
- All adds are 32-bit modulo; carry is dropped.
- cdb_req = s2_valid, registered, so there is no combinational dependence on flush.
- cdb_out.commit_valid = s2_valid && cdb_grant. dest_ROB and rd_v are always driven from S2.
- br_resolve_valid = s2_valid && cdb_grant.
- Backpressure: S2 holds its value unchanged while cdb_grant = 0. S1 holds when S2 is full and not granted.
- Flush kill rule, applied to each of S1, S2 and an incoming accept. An entry with tag t is killed when:
  - (t.sign == flush_tag.sign and (t.tag & flush_tag.tag) == flush_tag.tag), or
  - (t.sign != flush_tag.sign and (t.tag & flush_tag.tag) == t.tag).
- On kill, the valid bit clears at the edge.
- Flush with cdb_grant in the same cycle: the broadcast occurs (it is already visible) and S2 then empties. An S1 entry moving into S2 that same edge is also checked and is dropped if killed.
- A flush coinciding with an accept still asserts commit_taken; the instruction is discarded if killed.
- Non-killed entries proceed normally during flush.
- Reset asserted mid-operation clears all state immediately; no partial broadcast after release.

Test Plan:
- BEQ with op1 = op2 = 0x1234, pc = 0x100, imm = 0x20, grant held 1 -> cdb_req at N+2; br_taken = 1, br_target = 0x120, rd_v = 0, dest_ROB echoed.
- BLT op1 = 0xFFFFFFFF, op2 = 1 -> taken = 1. BLTU with the same operands -> taken = 0, target = pc + 4.
- JALR op1 = 0x2001, imm = 0x4, pc = 0x40 -> br_target = 0x2004 (LSB cleared), rd_v = 0x44.
- Issue three back-to-back with cdb_grant = 0:
  - Two accepted; running = 1 on the third cycle; commit_taken = 0.
  - Raising grant frees one slot per cycle; results emerge in order.
- Flush with tag matching the S2 entry while grant = 0 -> cdb_req drops next cycle; an unrelated-tag S1 entry survives and broadcasts after.
- Assert rst = 0 asynchronously with S1/S2 full -> cdb_req, running and br_resolve_valid are 0 immediately and stay 0 after release until a new issue.

Source files
------------

// File: rtl/cmp_fu.sv
// ============================================================================
// Module   : cmp_fu
// Brief    : Two-stage compare/branch functional unit (operand S1, result S2)
//            with CDB hand-off, branch resolution output and tag-based flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cmp_fu_pkg;
    localparam int BR_TAG_WIDTH = 4;

    typedef struct packed {
        logic                    sign;
        logic [BR_TAG_WIDTH-1:0] tag;
    } branch_tag_t;
endpackage

module cmp_fu
    import cmp_fu_pkg::*;
#(
    parameter int ROB_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  branch_tag_t            flush_tag,
    input  logic                   issue,
    input  logic [31:0]            operand1,
    input  logic [31:0]            operand2,
    input  branch_tag_t            br_tag_in,
    input  logic [ROB_WIDTH-1:0]   dest_ROB_in,
    input  logic                   cmp_type_in,
    input  logic [2:0]             cmp_op_in,
    input  logic [31:0]            imm_val_in,
    input  logic [31:0]            pc_val_in,
    output logic                   running,
    output logic                   commit_taken,
    output logic                   cdb_req,
    input  logic                   cdb_grant,
    output logic [ROB_WIDTH+32:0]  cdb_out,
    output logic                   br_resolve_valid,
    output logic                   br_taken,
    output logic [31:0]            br_target,
    output branch_tag_t            br_tag_out
);

    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_BLTU = 3'b110;
    localparam logic [2:0] c_F3_BGEU = 3'b111;

    // Same-sign flush kills descendants (superset of the flush tag bits);
    // opposite-sign flush kills entries whose bits are a subset of it.
    function automatic logic is_killed(input branch_tag_t t, input branch_tag_t f);
        if (t.sign == f.sign)
            return (t.tag & f.tag) == f.tag;
        else
            return (t.tag & f.tag) == t.tag;
    endfunction

    // ---------------- S1 (operand stage) registers ----------------
    logic                  r_s1_valid;
    logic [31:0]           r_s1_op1;
    logic [31:0]           r_s1_op2;
    branch_tag_t           r_s1_tag;
    logic [ROB_WIDTH-1:0]  r_s1_rob;
    logic                  r_s1_type;
    logic [2:0]            r_s1_op;
    logic [31:0]           r_s1_imm;
    logic [31:0]           r_s1_pc;

    // ---------------- S2 (result stage) registers ----------------
    logic                  r_s2_valid;
    logic [ROB_WIDTH-1:0]  r_s2_rob;
    logic [31:0]           r_s2_rd_v;
    logic                  r_s2_taken;
    logic [31:0]           r_s2_target;
    branch_tag_t           r_s2_tag;

    // ---------------- pipeline control ----------------
    logic w_s2_free;
    logic w_s1_free;
    logic w_grant_hit;
    logic w_kill_in;
    logic w_kill_s1;
    logic w_kill_s2;

    assign w_s2_free    = !r_s2_valid || cdb_grant;
    assign w_s1_free    = !r_s1_valid || w_s2_free;
    assign running      = !w_s1_free;
    // Gated by reset so nothing is reported as accepted while held in reset.
    assign commit_taken = issue && w_s1_free && rst;
    assign w_grant_hit  = r_s2_valid && cdb_grant;

    assign w_kill_in = flush && is_killed(br_tag_in, flush_tag);
    assign w_kill_s1 = flush && is_killed(r_s1_tag,  flush_tag);
    assign w_kill_s2 = flush && is_killed(r_s2_tag,  flush_tag);

    // ---------------- result computation from S1 ----------------
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_plus_imm;
    logic [31:0] w_jalr_target;
    logic        w_eq;
    logic        w_lt_s;
    logic        w_lt_u;
    logic        w_cond;
    logic        w_taken;
    logic [31:0] w_target;
    logic [31:0] w_rd_v;

    assign w_pc_plus4    = r_s1_pc + 32'd4;
    assign w_pc_plus_imm = r_s1_pc + r_s1_imm;
    assign w_jalr_target = (r_s1_op1 + r_s1_imm) & ~32'h1;
    assign w_eq          = (r_s1_op1 == r_s1_op2);
    assign w_lt_s        = ($signed(r_s1_op1) < $signed(r_s1_op2));
    assign w_lt_u        = (r_s1_op1 < r_s1_op2);

    always_comb begin
        w_cond = 1'b0;
        case (r_s1_op)
            c_F3_BEQ:  w_cond = w_eq;
            c_F3_BNE:  w_cond = !w_eq;
            c_F3_BLT:  w_cond = w_lt_s;
            c_F3_BGE:  w_cond = !w_lt_s;
            c_F3_BLTU: w_cond = w_lt_u;
            c_F3_BGEU: w_cond = !w_lt_u;
            default:   w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_taken  = 1'b0;
        w_target = w_pc_plus4;
        w_rd_v   = 32'd0;
        if (r_s1_type) begin
            w_taken  = 1'b1;
            w_target = r_s1_op[0] ? w_jalr_target : w_pc_plus_imm;
            w_rd_v   = w_pc_plus4;
        end else begin
            w_taken  = w_cond;
            w_target = w_cond ? w_pc_plus_imm : w_pc_plus4;
        end
    end

    // ---------------- S1 register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op1   <= '0;
            r_s1_op2   <= '0;
            r_s1_tag   <= '0;
            r_s1_rob   <= '0;
            r_s1_type  <= 1'b0;
            r_s1_op    <= '0;
            r_s1_imm   <= '0;
            r_s1_pc    <= '0;
        end else if (commit_taken) begin
            r_s1_valid <= !w_kill_in;
            r_s1_op1   <= operand1;
            r_s1_op2   <= operand2;
            r_s1_tag   <= br_tag_in;
            r_s1_rob   <= dest_ROB_in;
            r_s1_type  <= cmp_type_in;
            r_s1_op    <= cmp_op_in;
            r_s1_imm   <= imm_val_in;
            r_s1_pc    <= pc_val_in;
        end else if (w_s1_free) begin
            // Either empty already or its entry moves into S2 this edge.
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s1_valid && !w_kill_s1;
        end
    end

    // ---------------- S2 register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_rob    <= '0;
            r_s2_rd_v   <= '0;
            r_s2_taken  <= 1'b0;
            r_s2_target <= '0;
            r_s2_tag    <= '0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid && !w_kill_s1;
            if (r_s1_valid) begin
                r_s2_rob    <= r_s1_rob;
                r_s2_rd_v   <= w_rd_v;
                r_s2_taken  <= w_taken;
                r_s2_target <= w_target;
                r_s2_tag    <= r_s1_tag;
            end
        end else begin
            r_s2_valid <= !w_kill_s2;
        end
    end

    // ---------------- outputs ----------------
    assign cdb_req          = r_s2_valid;
    assign cdb_out          = {r_s2_rob, r_s2_rd_v, w_grant_hit};
    assign br_resolve_valid = w_grant_hit;
    assign br_taken         = r_s2_taken;
    assign br_target        = r_s2_target;
    assign br_tag_out       = r_s2_tag;

endmodule

`default_nettype wire

// File: tb/tb_cmp_fu.sv
// ============================================================================
// Module   : tb_cmp_fu
// Brief    : Directed self-checking bench for cmp_fu.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cmp_fu;
    import cmp_fu_pkg::*;

    localparam int ROB_WIDTH = 3;

    logic                  clk;
    logic                  rst;
    logic                  flush;
    branch_tag_t           flush_tag;
    logic                  issue;
    logic [31:0]           operand1;
    logic [31:0]           operand2;
    branch_tag_t           br_tag_in;
    logic [ROB_WIDTH-1:0]  dest_ROB_in;
    logic                  cmp_type_in;
    logic [2:0]            cmp_op_in;
    logic [31:0]           imm_val_in;
    logic [31:0]           pc_val_in;
    logic                  running;
    logic                  commit_taken;
    logic                  cdb_req;
    logic                  cdb_grant;
    logic [ROB_WIDTH+32:0] cdb_out;
    logic                  br_resolve_valid;
    logic                  br_taken;
    logic [31:0]           br_target;
    branch_tag_t           br_tag_out;

    int n_total = 0;
    int n_bad   = 0;

    cmp_fu #(.ROB_WIDTH(ROB_WIDTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .flush_tag        (flush_tag),
        .issue            (issue),
        .operand1         (operand1),
        .operand2         (operand2),
        .br_tag_in        (br_tag_in),
        .dest_ROB_in      (dest_ROB_in),
        .cmp_type_in      (cmp_type_in),
        .cmp_op_in        (cmp_op_in),
        .imm_val_in       (imm_val_in),
        .pc_val_in        (pc_val_in),
        .running          (running),
        .commit_taken     (commit_taken),
        .cdb_req          (cdb_req),
        .cdb_grant        (cdb_grant),
        .cdb_out          (cdb_out),
        .br_resolve_valid (br_resolve_valid),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .br_tag_out       (br_tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg,
                         input logic [2:0] rob, input logic ty, input logic [2:0] op,
                         input logic [31:0] imm, input logic [31:0] pc);
        issue       = 1'b1;
        operand1    = a;
        operand2    = b;
        br_tag_in   = tg;
        dest_ROB_in = rob;
        cmp_type_in = ty;
        cmp_op_in   = op;
        imm_val_in  = imm;
        pc_val_in   = pc;
    endtask

    function automatic logic [35:0] cdb_word(input logic [2:0] rob, input logic [31:0] rdv,
                                             input logic cv);
        return {rob, rdv, cv};
    endfunction

    // One instruction through an idle unit with grant held high.
    task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tg, input logic [2:0] rob, input logic ty,
                           input logic [2:0] op, input logic [31:0] imm, input logic [31:0] pc,
                           input logic exp_taken, input logic [31:0] exp_target,
                           input logic [31:0] exp_rdv);
        cdb_grant = 1'b1;
        drive(a, b, tg, rob, ty, op, imm, pc);
        #1;
        check({name, ".accept"}, commit_taken, 1'b1);
        tick();
        issue = 1'b0;
        #1;
        check({name, ".req_n1"}, cdb_req, 1'b0);
        tick();
        #1;
        check({name, ".req_n2"}, cdb_req, 1'b1);
        check({name, ".resolve"}, br_resolve_valid, 1'b1);
        check({name, ".taken"}, br_taken, exp_taken);
        check({name, ".target"}, br_target, exp_target);
        check({name, ".cdb"}, cdb_out, cdb_word(rob, exp_rdv, 1'b1));
        check({name, ".tag"}, br_tag_out, tg);
        tick();
        #1;
        check({name, ".drain"}, cdb_req, 1'b0);
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        flush_tag = '0;
        cdb_grant = 1'b0;
        drive('0, '0, '0, '0, 1'b0, '0, '0, '0);
        issue = 1'b1;
        #12;
        check("rst.running", running, 1'b0);
        check("rst.commit", commit_taken, 1'b0);
        check("rst.req", cdb_req, 1'b0);
        check("rst.cdb", cdb_out, '0);
        check("rst.resolve", br_resolve_valid, 1'b0);
        check("rst.target", br_target, '0);
        issue = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Directed compare / jump vectors
        run_one("beq",  32'h1234, 32'h1234, 5'h01, 3'd5, 1'b0, 3'b000, 32'h20, 32'h100,
                1'b1, 32'h120, 32'h0);
        run_one("bne",  32'h1234, 32'h1234, 5'h02, 3'd1, 1'b0, 3'b001, 32'h20, 32'h100,
                1'b0, 32'h104, 32'h0);
        run_one("blt",  32'hFFFFFFFF, 32'h1, 5'h03, 3'd2, 1'b0, 3'b100, 32'h10, 32'h200,
                1'b1, 32'h210, 32'h0);
        run_one("bltu", 32'hFFFFFFFF, 32'h1, 5'h04, 3'd3, 1'b0, 3'b110, 32'h10, 32'h200,
                1'b0, 32'h204, 32'h0);
        run_one("bge",  32'hFFFFFFFF, 32'h1, 5'h05, 3'd4, 1'b0, 3'b101, 32'h10, 32'h300,
                1'b0, 32'h304, 32'h0);
        run_one("bgeu", 32'hFFFFFFFF, 32'h1, 5'h06, 3'd6, 1'b0, 3'b111, 32'h10, 32'h300,
                1'b1, 32'h310, 32'h0);
        run_one("op010", 32'h5, 32'h5, 5'h07, 3'd7, 1'b0, 3'b010, 32'h10, 32'h400,
                1'b0, 32'h404, 32'h0);
        run_one("jalr", 32'h2001, 32'h0, 5'h08, 3'd0, 1'b1, 3'b001, 32'h4, 32'h40,
                1'b1, 32'h2004, 32'h44);
        run_one("jal",  32'h0, 32'h0, 5'h09, 3'd1, 1'b1, 3'b000, 32'hFFFFFFF0, 32'h1000,
                1'b1, 32'hFF0, 32'h1004);
        run_one("wrap", 32'h0, 32'h0, 5'h0A, 3'd2, 1'b1, 3'b000, 32'h10, 32'hFFFFFFF8,
                1'b1, 32'h8, 32'hFFFFFFFC);

        // Backpressure: three back-to-back issues with grant low
        cdb_grant = 1'b0;
        drive(32'h1, 32'h1, 5'h01, 3'd1, 1'b0, 3'b000, 32'h8, 32'h500);
        #1;
        check("bp.acc_a", commit_taken, 1'b1);
        tick();
        drive(32'h1, 32'h2, 5'h01, 3'd2, 1'b0, 3'b000, 32'h8, 32'h600);
        #1;
        check("bp.acc_b", commit_taken, 1'b1);
        tick();
        drive(32'h1, 32'h2, 5'h01, 3'd3, 1'b0, 3'b001, 32'h8, 32'h700);
        #1;
        check("bp.running", running, 1'b1);
        check("bp.no_acc_c", commit_taken, 1'b0);
        check("bp.hold_req", cdb_req, 1'b1);
        check("bp.hold_cdb", cdb_out, cdb_word(3'd1, 32'h0, 1'b0));
        tick();
        #1;
        check("bp.still_full", running, 1'b1);
        check("bp.held_target", br_target, 32'h508);
        cdb_grant = 1'b1;
        #1;
        check("bp.free_run", running, 1'b0);
        check("bp.acc_c", commit_taken, 1'b1);
        check("bp.out_a", cdb_out, cdb_word(3'd1, 32'h0, 1'b1));
        tick();
        issue = 1'b0;
        #1;
        check("bp.out_b", cdb_out, cdb_word(3'd2, 32'h0, 1'b1));
        check("bp.b_target", br_target, 32'h604);
        tick();
        #1;
        check("bp.out_c", cdb_out, cdb_word(3'd3, 32'h0, 1'b1));
        check("bp.c_target", br_target, 32'h708);
        tick();
        #1;
        check("bp.empty", cdb_req, 1'b0);

        // Flush targeting S2 while grant is low; unrelated S1 entry survives
        cdb_grant = 1'b0;
        drive(32'h0, 32'h0, 5'b0_0001, 3'd4, 1'b1, 3'b000, 32'h40, 32'h800);
        tick();
        drive(32'h0, 32'h0, 5'b0_0010, 3'd5, 1'b1, 3'b000, 32'h80, 32'h900);
        tick();
        issue     = 1'b0;
        flush     = 1'b1;
        flush_tag = 5'b0_0001;
        #1;
        check("fl.req_before", cdb_req, 1'b1);
        tick();
        flush = 1'b0;
        #1;
        check("fl.req_killed", cdb_req, 1'b0);
        tick();
        #1;
        check("fl.survivor_req", cdb_req, 1'b1);
        cdb_grant = 1'b1;
        #1;
        check("fl.survivor_cdb", cdb_out, cdb_word(3'd5, 32'h904, 1'b1));
        check("fl.survivor_tag", br_tag_out, 5'b0_0010);
        check("fl.survivor_tgt", br_target, 32'h980);
        tick();
        #1;
        check("fl.drained", cdb_req, 1'b0);

        // Opposite-sign flush kills an incoming accept that is a subset
        drive(32'h0, 32'h0, 5'b0_0001, 3'd6, 1'b1, 3'b000, 32'h4, 32'hA00);
        flush     = 1'b1;
        flush_tag = 5'b1_0011;
        #1;
        check("fli.accept", commit_taken, 1'b1);
        tick();
        issue = 1'b0;
        flush = 1'b0;
        tick();
        #1;
        check("fli.discarded", cdb_req, 1'b0);

        // Asynchronous reset with S1/S2 full
        cdb_grant = 1'b0;
        drive(32'h3, 32'h3, 5'h01, 3'd1, 1'b0, 3'b000, 32'h4, 32'hB00);
        tick();
        drive(32'h3, 32'h3, 5'h01, 3'd2, 1'b0, 3'b000, 32'h4, 32'hC00);
        tick();
        issue = 1'b0;
        #1;
        check("ar.full", running, 1'b1);
        #1;
        rst       = 1'b0;
        cdb_grant = 1'b1;
        #1;
        check("ar.req", cdb_req, 1'b0);
        check("ar.running", running, 1'b0);
        check("ar.resolve", br_resolve_valid, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        #1;
        check("ar.post_req", cdb_req, 1'b0);
        check("ar.post_resolve", br_resolve_valid, 1'b0);
        run_one("after", 32'h7, 32'h8, 5'h0C, 3'd3, 1'b0, 3'b110, 32'h100, 32'hD00,
                1'b1, 32'hE00, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
